psum_axis_out: RTL and testbench

Output stage directly downstream of the MAC array datapath. Accepts the packed partial-sum vector (one signed PSUM_WIDTH lane per MAC) and accumulates a programmable number of vectors into per-lane saturating accumulators. It then serialises the result, with optional ReLU, onto an AXI4-Stream master. This master is the datapath's output stream toward the DMA.

---
 rtl/psum_axis_out.sv | 182 ++++++++++++++++++
 tb/tb_psum_axis_out.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_axis_out.sv
// psum_axis_out
//   Output stage after the MAC array. Packed partial-sum vectors are accumulated
//   for a programmable number of passes into per-lane saturating accumulators.
//   The finished frame is then streamed out on an AXI4-Stream master with
//   optional ReLU.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   psum_in/valid/ready   packed signed lanes in; lane k at [k*PSUM_WIDTH +: PSUM_WIDTH]
//   acc_count, relu_en    frame setup; latched on the first vector of a frame
//   M_AXIS_*              stream master; lowest lane of a beat in the LSBs
//   busy                  frame in progress (ACCUM or DRAIN)
//   frame_done            one-cycle pulse in the cycle after the TLAST handshake
//   dbg_state_o           current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. A producer holds valid and its payload stable until that edge. Valid
// never depends on ready in the same cycle.
module psum_axis_out #(
  parameter int MAC_NUM              = 256,
  parameter int PSUM_WIDTH           = 5,
  parameter int ACC_WIDTH            = 16,
  parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PSUM_WIDTH*MAC_NUM-1:0]     psum_in,
  input  logic                              psum_valid,
  output logic                              psum_ready,
  input  logic [7:0]                        acc_count,
  input  logic                              relu_en,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic                              busy,
  output logic                              frame_done,
  output logic [1:0]                        dbg_state_o
);

  localparam int LANES_PER_BEAT = C_M_AXIS_TDATA_WIDTH / ACC_WIDTH;
  localparam int BEATS          = MAC_NUM / LANES_PER_BEAT;
  localparam int BIDX_W         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ACC_BITS       = MAC_NUM * ACC_WIDTH;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  function automatic logic [ACC_WIDTH-1:0] sext(input logic [PSUM_WIDTH-1:0] p);
    sext = {{(ACC_WIDTH-PSUM_WIDTH){p[PSUM_WIDTH-1]}}, p};
  endfunction

  // One guard bit holds the exact sum; overflow shows as the top two bits differing.
  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0]  a,
                                                   input logic [PSUM_WIDTH-1:0] p);
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH-PSUM_WIDTH+1){p[PSUM_WIDTH-1]}}, p};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) sat_add = s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    else                                sat_add = s[ACC_WIDTH-1:0];
  endfunction

  state_t                state_q, state_d;
  logic [ACC_BITS-1:0]   acc_q, acc_d;
  logic [7:0]            pass_cnt_q, pass_cnt_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  relu_q, relu_d;
  logic [BIDX_W-1:0]     beat_idx_q, beat_idx_d;
  logic                  frame_done_q, frame_done_d;

  logic [ACC_BITS-1:0]   load_vec;
  logic [ACC_BITS-1:0]   sum_vec;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] beat_raw;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] beat_out;
  int                    beat_base;
  logic                  accept;
  logic                  beat_hs;
  logic                  last_beat;

  assign psum_ready    = (state_q != S_DRAIN);
  assign M_AXIS_TVALID = (state_q == S_DRAIN);
  assign last_beat     = (beat_idx_q == BIDX_W'(BEATS-1));
  assign M_AXIS_TLAST  = M_AXIS_TVALID && last_beat;
  assign M_AXIS_TSTRB  = {(C_M_AXIS_TDATA_WIDTH/8){M_AXIS_TVALID}};
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? beat_out : '0;
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = frame_done_q;
  assign dbg_state_o   = state_q;
  assign accept        = psum_valid && psum_ready;
  assign beat_hs       = M_AXIS_TVALID && M_AXIS_TREADY;

  // Per-lane candidates: first vector of a frame overwrites, later ones add.
  always_comb begin
    load_vec = '0;
    sum_vec  = '0;
    for (int k = 0; k < MAC_NUM; k++) begin
      load_vec[k*ACC_WIDTH +: ACC_WIDTH] = sext(psum_in[k*PSUM_WIDTH +: PSUM_WIDTH]);
      sum_vec[k*ACC_WIDTH +: ACC_WIDTH]  = sat_add(acc_q[k*ACC_WIDTH +: ACC_WIDTH],
                                                   psum_in[k*PSUM_WIDTH +: PSUM_WIDTH]);
    end
  end

  // Lanes are packed contiguously, so a beat is one aligned slice of acc_q.
  always_comb begin
    beat_base = int'(beat_idx_q) * C_M_AXIS_TDATA_WIDTH;
    beat_raw  = acc_q[beat_base +: C_M_AXIS_TDATA_WIDTH];
    beat_out  = '0;
    for (int l = 0; l < LANES_PER_BEAT; l++) begin
      if (relu_q && beat_raw[l*ACC_WIDTH + ACC_WIDTH - 1])
        beat_out[l*ACC_WIDTH +: ACC_WIDTH] = '0;
      else
        beat_out[l*ACC_WIDTH +: ACC_WIDTH] = beat_raw[l*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    pass_cnt_d   = pass_cnt_q;
    cnt_d        = cnt_q;
    relu_d       = relu_q;
    beat_idx_d   = beat_idx_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d      = load_vec;
          pass_cnt_d = 8'd1;
          cnt_d      = (acc_count == 8'd0) ? 8'd1 : acc_count;
          relu_d     = relu_en;
          state_d    = (cnt_d == 8'd1) ? S_DRAIN : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          acc_d      = sum_vec;
          pass_cnt_d = pass_cnt_q + 8'd1;
          if (pass_cnt_d == cnt_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (beat_hs) begin
          if (last_beat) begin
            beat_idx_d   = '0;
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end else begin
            beat_idx_d = beat_idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      pass_cnt_q   <= '0;
      cnt_q        <= '0;
      relu_q       <= 1'b0;
      beat_idx_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      pass_cnt_q   <= pass_cnt_d;
      cnt_q        <= cnt_d;
      relu_q       <= relu_d;
      beat_idx_q   <= beat_idx_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_psum_axis_out.sv
// Bench for psum_axis_out: a 4-lane 16-bit instance checked through a beat
// scoreboard, plus a 4-lane 8-bit instance for the narrow saturation case.
module tb_psum_axis_out;
  localparam int MAC = 4;
  localparam int PW  = 5;
  localparam int AW  = 16;
  localparam int TDW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 16-bit instance
  logic [PW*MAC-1:0] psum_in = '0;
  logic              psum_valid = 1'b0;
  logic              psum_ready;
  logic [7:0]        acc_count = 8'd1;
  logic              relu_en = 1'b0;
  logic [TDW-1:0]    tdata;
  logic [TDW/8-1:0]  tstrb;
  logic              tvalid, tlast;
  logic              tready = 1'b1;
  logic              busy, frame_done;
  logic [1:0]        dbg_state;

  psum_axis_out #(.MAC_NUM(MAC), .PSUM_WIDTH(PW), .ACC_WIDTH(AW),
                  .C_M_AXIS_TDATA_WIDTH(TDW)) dut (
    .clk(clk), .rst(rst), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .acc_count(acc_count), .relu_en(relu_en),
    .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb), .M_AXIS_TVALID(tvalid),
    .M_AXIS_TLAST(tlast), .M_AXIS_TREADY(tready), .busy(busy),
    .frame_done(frame_done), .dbg_state_o(dbg_state));

  // 8-bit instance (one beat per frame)
  logic [PW*MAC-1:0] b_psum_in = '0;
  logic              b_valid = 1'b0;
  logic              b_ready;
  logic [7:0]        b_cnt = 8'd1;
  logic              b_relu = 1'b0;
  logic [TDW-1:0]    b_tdata;
  logic [TDW/8-1:0]  b_tstrb;
  logic              b_tvalid, b_tlast;
  logic              b_tready = 1'b1;
  logic              b_busy, b_done;
  logic [1:0]        b_state;

  psum_axis_out #(.MAC_NUM(MAC), .PSUM_WIDTH(PW), .ACC_WIDTH(8),
                  .C_M_AXIS_TDATA_WIDTH(TDW)) dut8 (
    .clk(clk), .rst(rst), .psum_in(b_psum_in), .psum_valid(b_valid),
    .psum_ready(b_ready), .acc_count(b_cnt), .relu_en(b_relu),
    .M_AXIS_TDATA(b_tdata), .M_AXIS_TSTRB(b_tstrb), .M_AXIS_TVALID(b_tvalid),
    .M_AXIS_TLAST(b_tlast), .M_AXIS_TREADY(b_tready), .busy(b_busy),
    .frame_done(b_done), .dbg_state_o(b_state));

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];   // {tlast, tdata}
  int beats_seen = 0;
  int last_tlast_cyc = 0;
  int prev_tlast_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW*MAC-1:0] pk(input int a, input int b, input int c, input int d);
    pk = {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic int clip(input int x, input int w);
    int hi;
    int lo;
    hi = (1 << (w-1)) - 1;
    lo = -(1 << (w-1));
    clip = (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  // Model of one frame made of n copies of the same vector; pushes both beats.
  task automatic model_push(input int l0, input int l1, input int l2, input int l3,
                            input int n, input bit relu);
    int lane[4];
    int acc[4];
    logic [15:0] h[4];
    lane = '{l0, l1, l2, l3};
    for (int k = 0; k < 4; k++) acc[k] = 0;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++)
        acc[k] = (i == 0) ? lane[k] : clip(acc[k] + lane[k], AW);
    for (int k = 0; k < 4; k++) begin
      if (relu && acc[k] < 0) acc[k] = 0;
      h[k] = 16'(acc[k]);
    end
    exp_q.push_back({1'b0, h[1], h[0]});
    exp_q.push_back({1'b1, h[3], h[2]});
  endtask

  // monitor: beats are compared at the negedge before the handshake edge
  always @(negedge clk) begin
    if (!rst && tvalid && tready) begin
      check("tstrb", 64'(tstrb), 64'hF);
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'({tlast, tdata}), 64'h1_FFFF_FFFF_F);
      end else begin
        check("beat", 64'({tlast, tdata}), 64'(exp_q.pop_front()));
      end
      beats_seen++;
      if (tlast) begin
        prev_tlast_cyc = last_tlast_cyc;
        last_tlast_cyc = cyc;
      end
    end
  end

  // driver tasks
  task automatic send_vec(input logic [PW*MAC-1:0] v);
    int g;
    g = 0;
    psum_in    = v;
    psum_valid = 1'b1;
    while (psum_ready !== 1'b1 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("send_ready_wait", 64'(g < 200), 64'd1);
    @(posedge clk); #1;
    psum_valid = 1'b0;
  endtask

  task automatic run_frame(input int l0, input int l1, input int l2, input int l3,
                           input int n, input logic [7:0] cnt, input bit relu);
    acc_count = cnt;
    relu_en   = relu;
    for (int i = 0; i < n; i++) send_vec(pk(l0, l1, l2, l3));
  endtask

  task automatic wait_done(input string tag);
    int g;
    g = 0;
    while (frame_done !== 1'b1 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check({tag, "_done"}, 64'(frame_done), 64'd1);
    check({tag, "_ready_at_done"}, 64'(psum_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bs;
    logic [32:0] held;
    // reset values
    #2;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(psum_ready), 64'd1);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // single vector, known beats
    exp_q.push_back(33'h0_FFFE0001);
    exp_q.push_back(33'h1_FFFC0003);
    run_frame(1, -2, 3, -4, 1, 8'd1, 1'b0);
    check("single_latency_tvalid", 64'(tvalid), 64'd1);
    check("single_b0_tlast", 64'(tlast), 64'd0);
    check("single_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("single_b1_tlast", 64'(tlast), 64'd1);
    @(posedge clk); #1;
    check("single_done", 64'(frame_done), 64'd1);
    check("single_done_tvalid", 64'(tvalid), 64'd0);
    check("single_done_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1;
    check("single_done_pulse", 64'(frame_done), 64'd0);

    // three-vector accumulate with ReLU; mid-frame setup changes ignored
    exp_q.push_back(33'h0_00000003);
    exp_q.push_back(33'h1_00000009);
    acc_count = 8'd3;
    relu_en   = 1'b1;
    send_vec(pk(1, -2, 3, -4));
    acc_count = 8'd1;
    relu_en   = 1'b0;
    send_vec(pk(1, -2, 3, -4));
    check("relu_still_accum", 64'(tvalid), 64'd0);
    send_vec(pk(1, -2, 3, -4));
    check("relu_ready_b0", 64'(psum_ready), 64'd0);
    @(posedge clk); #1;
    check("relu_ready_b1", 64'(psum_ready), 64'd0);
    wait_done("relu");

    // acc_count = 0 behaves as 1
    model_push(-16, 15, 0, 7, 1, 1'b0);
    run_frame(-16, 15, 0, 7, 1, 8'd0, 1'b0);
    check("cnt0_drain", 64'(tvalid), 64'd1);
    wait_done("cnt0");

    // 255 passes at 16 bits, no overflow on lane0
    model_push(15, -1, 2, -16, 255, 1'b0);
    run_frame(15, -1, 2, -16, 255, 8'hFF, 1'b0);
    check("sat16_lane0", 64'(tdata[15:0]), 64'd3825);
    wait_done("sat16");

    // backpressure: TREADY 1,0,0,1
    model_push(5, 6, -7, 8, 1, 1'b0);
    bs = beats_seen;
    run_frame(5, 6, -7, 8, 1, 8'd1, 1'b0);
    tready = 1'b1;
    @(posedge clk); #1;
    tready = 1'b0;
    held = {1'b1, 16'h0008, 16'hFFF9};
    check("bp_stall1", 64'({tlast, tdata}), 64'(held));
    @(posedge clk); #1;
    check("bp_stall2", 64'({tlast, tdata}), 64'(held));
    check("bp_stall_tvalid", 64'(tvalid), 64'd1);
    @(posedge clk); #1;
    check("bp_stall3", 64'({tlast, tdata}), 64'(held));
    tready = 1'b1;
    wait_done("bp");
    check("bp_handshakes", 64'(beats_seen - bs), 64'd2);

    // back-to-back frames, psum_valid held high
    acc_count = 8'd1;
    relu_en   = 1'b0;
    model_push(7, -8, 1, 0, 1, 1'b0);
    model_push(-3, 4, -5, 6, 1, 1'b0);
    psum_in    = pk(7, -8, 1, 0);
    psum_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_first_accept", 64'(tvalid), 64'd1);
    psum_in = pk(-3, 4, -5, 6);
    wait_done("b2b1");
    @(posedge clk); #1;
    psum_valid = 1'b0;
    check("b2b_second_accept", 64'(tvalid), 64'd1);
    wait_done("b2b2");
    check("b2b_tlast_gap", 64'(last_tlast_cyc - prev_tlast_cyc), 64'd3);

    // reset mid-DRAIN after beat 0
    model_push(1, 2, 3, 4, 1, 1'b0);
    run_frame(1, 2, 3, 4, 1, 8'd1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 64'(tvalid), 64'd0);
    check("mid_rst_tlast", 64'(tlast), 64'd0);
    check("mid_rst_tdata", 64'(tdata), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(psum_ready), 64'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_state", 64'(dbg_state), 64'd0);
    model_push(-1, -2, -3, -4, 1, 1'b0);
    run_frame(-1, -2, -3, -4, 1, 8'd1, 1'b0);
    wait_done("post_rst");

    // 8-bit accumulators: +15 and -16 for 20 passes clip at 0x7F / 0x80
    b_cnt     = 8'd20;
    b_psum_in = pk(15, -16, 0, -1);
    b_valid   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    check("sat8_tvalid", 64'(b_tvalid), 64'd1);
    check("sat8_tdata", 64'(b_tdata), 64'hEC00807F);
    check("sat8_tlast", 64'(b_tlast), 64'd1);
    @(posedge clk); #1;
    check("sat8_done", 64'(b_done), 64'd1);
    check("sat8_idle", 64'(b_tvalid), 64'd0);

    // final report
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("beat_total", 64'(beats_seen), 64'd17);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
